// File: rtl/muon_pulse_trigger_pkg.sv
// Shared types, widths and helpers for the muon pulse trigger.
package muon_trig_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPulse,
        StHoldoff
    } state_e;

    localparam int unsigned HG_MSB   = 23;
    localparam int unsigned HG_LSB   = 12;
    localparam int unsigned ADC_W    = 12;
    localparam int unsigned CHARGE_W = 20;
    localparam int unsigned WIDTH_W  = 8;

    // Saturating accumulate of one non-negative sample into the charge sum.
    function automatic logic [CHARGE_W-1:0] sat_add_charge(input logic [CHARGE_W-1:0] acc,
                                                           input logic [ADC_W-1:0]    inc);
        logic [CHARGE_W:0] sum;
        sum = {1'b0, acc} + (CHARGE_W + 1)'(inc);
        return sum[CHARGE_W] ? {CHARGE_W{1'b1}} : sum[CHARGE_W-1:0];
    endfunction

endpackage

// File: rtl/muon_pulse_trigger_if.sv
// Event record port from the pulse trigger to the muon buffer writer.
interface muon_pulse_trigger_if;
    import muon_trig_pkg::*;

    logic                EVT_VALID;
    logic                EVT_READY;
    logic [ADC_W-1:0]    PEAK;
    logic [CHARGE_W-1:0] CHARGE;
    logic [WIDTH_W-1:0]  WIDTH;

    modport master (
        output EVT_VALID,
        output PEAK,
        output CHARGE,
        output WIDTH,
        input  EVT_READY
    );

    modport slave (
        input  EVT_VALID,
        input  PEAK,
        input  CHARGE,
        input  WIDTH,
        output EVT_READY
    );

endinterface

// File: rtl/pedestal_tracker.sv
// HG pedestal estimate: first-order IIR accumulator with a freeze input.
module pedestal_tracker
    import muon_trig_pkg::*;
#(
    parameter int unsigned PED_INIT  = 200,
    parameter int unsigned PED_SHIFT = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             freeze_i,
    input  logic [ADC_W-1:0] hg_i,
    output logic [ADC_W-1:0] baseline_o
);

    localparam int unsigned AccW = ADC_W + PED_SHIFT;
    localparam logic [AccW-1:0] AccInit = AccW'(PED_INIT * (2 ** PED_SHIFT));

    logic [AccW-1:0] acc_q;
    logic [AccW-1:0] acc_d;

    // acc - acc/2^S never exceeds (2^AccW - 2^ADC_W), so adding one sample cannot wrap.
    always_comb begin
        acc_d = acc_q;
        if (!freeze_i) begin
            acc_d = acc_q - (acc_q >> PED_SHIFT) + AccW'(hg_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= AccInit;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign baseline_o = acc_q[AccW-1:PED_SHIFT];

endmodule

// File: rtl/muon_pulse_trigger.sv
// Single-channel HG pulse finder: pedestal-relative threshold trigger with peak/charge/width.
module muon_pulse_trigger
    import muon_trig_pkg::*;
#(
    parameter int unsigned PED_INIT  = 200,
    parameter int unsigned PED_SHIFT = 6,
    parameter int unsigned HOLDOFF   = 16,
    parameter int unsigned MAX_LEN   = 255
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ENABLE,
    input  logic [HG_MSB:0]     ADC_IN,
    input  logic [ADC_W-1:0]    THRESHOLD,
    output logic                TRIG,
    output logic [ADC_W-1:0]    BASELINE,
    output logic [7:0]          DROP_COUNT,
    muon_pulse_trigger_if.master evt
);

    localparam int unsigned HoldW = ($clog2(HOLDOFF) > 0) ? $clog2(HOLDOFF) : 1;

    logic [ADC_W-1:0]    hg_q;
    logic [ADC_W:0]      diff;
    logic [ADC_W-1:0]    sig;
    logic                above;
    logic                ped_freeze;
    logic                unused_lg;

    state_e              state_q, state_d;
    logic                trig_q, trig_d;
    logic [ADC_W-1:0]    peak_q, peak_d;
    logic [CHARGE_W-1:0] charge_q, charge_d;
    logic [WIDTH_W-1:0]  width_q, width_d;
    logic [HoldW-1:0]    hold_q, hold_d;
    logic                evt_valid_q, evt_valid_d;
    logic [ADC_W-1:0]    evt_peak_q, evt_peak_d;
    logic [CHARGE_W-1:0] evt_charge_q, evt_charge_d;
    logic [WIDTH_W-1:0]  evt_width_q, evt_width_d;
    logic [7:0]          drop_q, drop_d;

    logic                close;
    logic [ADC_W-1:0]    rec_peak;
    logic [CHARGE_W-1:0] rec_charge;
    logic [WIDTH_W-1:0]  rec_width;

    assign unused_lg = ^ADC_IN[HG_LSB-1:0];

    // Input stage is a plain pipeline register; it needs no reset value.
    always_ff @(posedge CLK) begin
        hg_q <= ADC_IN[HG_MSB:HG_LSB];
    end

    assign diff  = {1'b0, hg_q} - {1'b0, BASELINE};
    assign sig   = diff[ADC_W] ? '0 : diff[ADC_W-1:0];
    assign above = (sig > THRESHOLD);

    assign ped_freeze = !((state_q == StIdle) && !above);

    pedestal_tracker #(
        .PED_INIT  (PED_INIT),
        .PED_SHIFT (PED_SHIFT)
    ) u_pedestal (
        .clk_i      (CLK),
        .rst_i      (RST),
        .freeze_i   (ped_freeze),
        .hg_i       (hg_q),
        .baseline_o (BASELINE)
    );

    always_comb begin
        state_d    = state_q;
        trig_d     = 1'b0;
        peak_d     = peak_q;
        charge_d   = charge_q;
        width_d    = width_q;
        hold_d     = hold_q;
        close      = 1'b0;
        rec_peak   = peak_q;
        rec_charge = charge_q;
        rec_width  = width_q;

        case (state_q)
            StIdle: begin
                if (ENABLE && above) begin
                    state_d  = StPulse;
                    trig_d   = 1'b1;
                    peak_d   = sig;
                    charge_d = CHARGE_W'(sig);
                    width_d  = WIDTH_W'(1);
                end
            end
            StPulse: begin
                if (!ENABLE) begin
                    state_d = StIdle;
                end else if (!above) begin
                    close = 1'b1;
                end else begin
                    peak_d     = (sig > peak_q) ? sig : peak_q;
                    charge_d   = sat_add_charge(charge_q, sig);
                    width_d    = width_q + 1'b1;
                    rec_peak   = peak_d;
                    rec_charge = charge_d;
                    rec_width  = width_d;
                    // The sample that reaches MAX_LEN is counted and closes the pulse at once.
                    close      = (width_d == WIDTH_W'(MAX_LEN));
                end
                if (close) begin
                    state_d = StHoldoff;
                    hold_d  = HoldW'(HOLDOFF - 1);
                end
            end
            StHoldoff: begin
                if (hold_q == '0) begin
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        evt_valid_d  = evt_valid_q;
        evt_peak_d   = evt_peak_q;
        evt_charge_d = evt_charge_q;
        evt_width_d  = evt_width_q;
        drop_d       = drop_q;

        if (close) begin
            if (!evt_valid_q || evt.EVT_READY) begin
                evt_valid_d  = 1'b1;
                evt_peak_d   = rec_peak;
                evt_charge_d = rec_charge;
                evt_width_d  = rec_width;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 1'b1;
            end
        end else if (evt_valid_q && evt.EVT_READY) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            trig_q       <= 1'b0;
            peak_q       <= '0;
            charge_q     <= '0;
            width_q      <= '0;
            hold_q       <= '0;
            evt_valid_q  <= 1'b0;
            evt_peak_q   <= '0;
            evt_charge_q <= '0;
            evt_width_q  <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            trig_q       <= trig_d;
            peak_q       <= peak_d;
            charge_q     <= charge_d;
            width_q      <= width_d;
            hold_q       <= hold_d;
            evt_valid_q  <= evt_valid_d;
            evt_peak_q   <= evt_peak_d;
            evt_charge_q <= evt_charge_d;
            evt_width_q  <= evt_width_d;
            drop_q       <= drop_d;
        end
    end

    assign TRIG       = trig_q;
    assign DROP_COUNT = drop_q;
    assign evt.EVT_VALID = evt_valid_q;
    assign evt.PEAK      = evt_peak_q;
    assign evt.CHARGE    = evt_charge_q;
    assign evt.WIDTH     = evt_width_q;

endmodule

// File: tb/tb_muon_pulse_trigger.sv
// Directed scenarios plus random pulses, all checked every cycle against a behavioural model.
module tb_muon_pulse_trigger;
    import muon_trig_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [23:0] adc;
    logic [11:0] thr;
    logic        trig;
    logic [11:0] baseline;
    logic [7:0]  drop;

    always #5 clk = ~clk;

    muon_pulse_trigger_if evt_if ();

    muon_pulse_trigger #(
        .PED_INIT  (200),
        .PED_SHIFT (6),
        .HOLDOFF   (16),
        .MAX_LEN   (255)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .ENABLE     (en),
        .ADC_IN     (adc),
        .THRESHOLD  (thr),
        .TRIG       (trig),
        .BASELINE   (baseline),
        .DROP_COUNT (drop),
        .evt        (evt_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    int tick_no  = 0;
    int trig_cnt = 0;
    int trig_at[$];

    // Reference model: pedestal as an integer accumulator, pulse as open flag + dead-cycle count.
    int m_hg, m_acc, m_dead, m_peak, m_chg, m_wid, m_drop;
    int r_peak, r_chg, r_wid;
    bit m_open, m_valid, m_trig;

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", tag, obs, exp, tick_no);
        end
    endtask

    task automatic model_edge();
        int  hg_now, base, sig, acc_next, th;
        bit  above, idle, close, rdy;
        hg_now = int'(adc[23:12]);
        th     = int'(thr);
        rdy    = evt_if.EVT_READY;
        m_trig = 1'b0;
        if (rst) begin
            m_acc = 200 * 64;
            m_open = 0; m_dead = 0; m_peak = 0; m_chg = 0; m_wid = 0;
            m_valid = 0; r_peak = 0; r_chg = 0; r_wid = 0; m_drop = 0;
            m_hg = hg_now;
            return;
        end
        base  = m_acc / 64;
        sig   = m_hg - base;
        if (sig < 0) sig = 0;
        above = (sig > th);
        idle  = !m_open && (m_dead == 0);
        acc_next = (idle && !above) ? m_acc + m_hg - base : m_acc;
        close = 1'b0;
        if (m_dead > 0) begin
            m_dead--;
        end else if (!m_open) begin
            if (en && above) begin
                m_open = 1; m_trig = 1; m_peak = sig; m_chg = sig; m_wid = 1;
            end
        end else if (!en) begin
            m_open = 0;
        end else if (!above) begin
            close = 1;
        end else begin
            if (sig > m_peak) m_peak = sig;
            m_chg += sig;
            if (m_chg > 1048575) m_chg = 1048575;
            m_wid++;
            if (m_wid == 255) close = 1;
        end
        if (close) begin
            m_open = 0;
            m_dead = 16;
            if (!m_valid || rdy) begin
                m_valid = 1; r_peak = m_peak; r_chg = m_chg; r_wid = m_wid;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        m_acc = acc_next;
        m_hg  = hg_now;
    endtask

    task automatic drive(input int hg);
        adc = {hg[11:0], 12'($urandom)};
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
        tick_no++;
        if (trig) begin
            trig_cnt++;
            trig_at.push_back(tick_no);
        end
        check_val("trig", trig, m_trig);
        check_val("baseline", baseline, m_acc / 64);
        check_val("evt_valid", evt_if.EVT_VALID, m_valid);
        check_val("drop", drop, m_drop);
        if (m_valid) begin
            check_val("peak", evt_if.PEAK, r_peak);
            check_val("charge", evt_if.CHARGE, r_chg);
            check_val("width", evt_if.WIDTH, r_wid);
        end
    endtask

    initial begin
        int prev, mono_bad, b0, gap, burst_left, amp;
        rst = 1'b1; en = 1'b1; thr = 12'd100; evt_if.EVT_READY = 1'b0;
        drive(200);
        repeat (2) tick();
        rst = 1'b0;

        // Quiet pedestal
        repeat (50) tick();
        check_val("t1_baseline", baseline, 200);
        check_val("t1_trig_cnt", trig_cnt, 0);
        check_val("t1_valid", evt_if.EVT_VALID, 0);

        // Single 4-sample pulse, record held until ready
        trig_cnt = 0;
        drive(2047); repeat (4) tick();
        drive(200);  repeat (30) tick();
        check_val("t2_trig_cnt", trig_cnt, 1);
        check_val("t2_valid", evt_if.EVT_VALID, 1);
        check_val("t2_peak", evt_if.PEAK, 1847);
        check_val("t2_charge", evt_if.CHARGE, 7388);
        check_val("t2_width", evt_if.WIDTH, 4);
        evt_if.EVT_READY = 1'b1; tick(); evt_if.EVT_READY = 1'b0;
        check_val("t2_valid_clr", evt_if.EVT_VALID, 0);

        // Second pulse while record still pending is dropped
        trig_cnt = 0;
        drive(2047); repeat (4) tick();
        drive(200);  repeat (96) tick();
        drive(2047); repeat (4) tick();
        drive(200);  repeat (30) tick();
        check_val("t3_trig_cnt", trig_cnt, 2);
        check_val("t3_drop", drop, 1);
        check_val("t3_valid", evt_if.EVT_VALID, 1);
        check_val("t3_width", evt_if.WIDTH, 4);
        check_val("t3_charge", evt_if.CHARGE, 7388);
        evt_if.EVT_READY = 1'b1; tick(); evt_if.EVT_READY = 1'b0;
        check_val("t3_valid_clr", evt_if.EVT_VALID, 0);

        // 300-sample pulse: forced close at MAX_LEN, hold-off, retrigger
        trig_cnt = 0; trig_at.delete();
        drive(2047); repeat (260) tick();
        check_val("t4_width1", evt_if.WIDTH, 255);
        check_val("t4_charge1", evt_if.CHARGE, 255 * 1847);
        check_val("t4_peak1", evt_if.PEAK, 1847);
        evt_if.EVT_READY = 1'b1; tick(); evt_if.EVT_READY = 1'b0;
        repeat (39) tick();
        drive(200); repeat (30) tick();
        gap = (trig_at.size() >= 2) ? trig_at[1] - trig_at[0] : -1;
        check_val("t4_trig_cnt", trig_cnt, 2);
        check_val("t4_trig_gap", gap, 271);
        check_val("t4_width2", evt_if.WIDTH, 29);
        check_val("t4_charge2", evt_if.CHARGE, 29 * 1847);
        check_val("t4_valid2", evt_if.EVT_VALID, 1);

        // Pedestal step 200 -> 250, then frozen during a pulse
        evt_if.EVT_READY = 1'b1;
        drive(250);
        prev = baseline; mono_bad = 0;
        repeat (600) begin
            tick();
            if (baseline < prev) mono_bad++;
            prev = baseline;
        end
        check_val("t5_monotonic", mono_bad, 0);
        check_val("t5_settled", (baseline >= 249 && baseline <= 250), 1);
        b0 = baseline;
        drive(2047); repeat (5) tick();
        check_val("t5_frozen", baseline, b0);
        drive(250); repeat (30) tick();

        // Reset mid-pulse
        evt_if.EVT_READY = 1'b0;
        drive(2047); repeat (3) tick();
        rst = 1'b1; drive(200); tick(); rst = 1'b0;
        trig_cnt = 0;
        repeat (30) tick();
        check_val("t6_rst_trig", trig_cnt, 0);
        check_val("t6_rst_valid", evt_if.EVT_VALID, 0);
        check_val("t6_rst_baseline", baseline, 200);

        // ENABLE dropped mid-pulse
        trig_cnt = 0;
        drive(2047); repeat (3) tick();
        en = 1'b0; repeat (10) tick();
        drive(200); tick();
        en = 1'b1; repeat (30) tick();
        check_val("t6_en_trig", trig_cnt, 1);
        check_val("t6_en_valid", evt_if.EVT_VALID, 0);
        check_val("t6_en_drop", drop, 0);

        // Random pulses, enable, ready and occasional reset
        burst_left = 0; amp = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) thr = 12'($urandom_range(20, 400));
            if (burst_left == 0 && $urandom_range(0, 39) == 0) begin
                burst_left = $urandom_range(1, 300);
                amp = $urandom_range(50, 3800);
            end
            if (burst_left > 0) begin
                drive(200 + amp - $urandom_range(0, 60));
                burst_left--;
            end else begin
                drive($urandom_range(180, 230));
            end
            en  = ($urandom_range(0, 31) != 0);
            evt_if.EVT_READY = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
